// File: rtl/regfile_scoreboard.sv
// Integer register file with same-cycle writeback bypass and a busy-bit
// scoreboard that stalls decode on RAW/WAW hazards against in-flight writes.
module regfile_scoreboard #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  write_back_data,
    input  logic [AW-1:0]    write_back_addr,
    input  logic             reg_write_back,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rd,
    input  logic             issue_reg_write,
    input  logic             flush,
    output logic             stall,
    output logic [NREGS-1:0] busy_vec
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;

    logic             w_rs1_byp;
    logic             w_rs2_byp;
    logic             w_rd_byp;
    logic             w_rs1_hz;
    logic             w_rs2_hz;
    logic             w_rd_hz;
    logic             w_issue_acc;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;

    // A register being written back this cycle is forwarded, so it is neither
    // stale data for a reader nor a hazard for the scoreboard.
    assign w_rs1_byp = reg_write_back && (write_back_addr == rs1_addr);
    assign w_rs2_byp = reg_write_back && (write_back_addr == rs2_addr);
    assign w_rd_byp  = reg_write_back && (write_back_addr == issue_rd);

    // Read ports: x0 reads zero, then bypass, then the array.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = w_rs1_byp ? write_back_data : r_regs[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rs2_data = w_rs2_byp ? write_back_data : r_regs[rs2_addr];
        end
    end

    // Busy bit 0 is never set, so x0 cannot raise a hazard.
    assign w_rs1_hz    = r_busy[rs1_addr] && !w_rs1_byp;
    assign w_rs2_hz    = r_busy[rs2_addr] && !w_rs2_byp;
    assign w_rd_hz     = issue_reg_write && r_busy[issue_rd] && !w_rd_byp;
    assign stall       = issue_valid && (w_rs1_hz || w_rs2_hz || w_rd_hz);
    assign w_issue_acc = issue_valid && issue_reg_write && !stall && !flush;

    assign w_set_mask  = {NREGS{w_issue_acc}} & (NREGS'(1) << issue_rd);
    assign w_clr_mask  = {NREGS{reg_write_back}} & (NREGS'(1) << write_back_addr);
    assign busy_vec    = r_busy;

    // Architectural register array; writes to x0 are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (reg_write_back && (write_back_addr != '0)) begin
            r_regs[write_back_addr] <= write_back_data;
        end
    end

    // Scoreboard: flush clears everything; a new issue to the same register
    // as a completing writeback wins, since the newer producer is now pending.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~NREGS'(1);
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios followed by random traffic,
// checked through an expectation queue drained by an independent monitor.
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] write_back_data;
    logic [4:0]  write_back_addr;
    logic        reg_write_back;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_reg_write;
    logic        flush;
    logic        stall;
    logic [31:0] busy_vec;

    regfile_scoreboard #(.XLEN(64), .NREGS(32), .AW(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .write_back_data (write_back_data),
        .write_back_addr (write_back_addr),
        .reg_write_back  (reg_write_back),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_reg_write (issue_reg_write),
        .flush           (flush),
        .stall           (stall),
        .busy_vec        (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        stall;
        logic [31:0] busy;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int ncyc     = 0;

    // Reference model: architectural state as plain arrays.
    logic [63:0] m_regs [32];
    bit          m_busy [32];

    function automatic logic [63:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (reg_write_back && write_back_addr == a) return write_back_data;
        return m_regs[a];
    endfunction

    function automatic bit m_pending(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (reg_write_back && write_back_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic bit m_stall();
        bit hz;
        hz = m_pending(rs1_addr) || m_pending(rs2_addr) ||
             (issue_reg_write && m_pending(issue_rd));
        return issue_valid && hz;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 64'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic chk64(input string name, input int cyc, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: outputs are settled by the falling edge; compare everything queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk64("rs1_data", e.cyc, rs1_data, e.rs1);
                chk64("rs2_data", e.cyc, rs2_data, e.rs2);
                chk64("stall", e.cyc, {63'd0, stall}, {63'd0, e.stall});
                chk64("busy_vec", e.cyc, {32'd0, busy_vec}, {32'd0, e.busy});
            end
        end
    end

    // One clock of stimulus: predict outputs, hand them to the monitor, then
    // advance the model across the edge.
    task automatic cycle();
        exp_t e;
        bit   st;
        e.cyc   = ncyc;
        e.rs1   = m_read(rs1_addr);
        e.rs2   = m_read(rs2_addr);
        st      = m_stall();
        e.stall = st;
        e.busy  = m_busy_vec();
        exp_q.push_back(e);
        @(posedge clk);
        if (reset) begin
            m_clear();
        end else begin
            if (reg_write_back && write_back_addr != 5'd0)
                m_regs[write_back_addr] = write_back_data;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            end else begin
                if (reg_write_back) m_busy[write_back_addr] = 1'b0;
                if (issue_valid && issue_reg_write && !st) m_busy[issue_rd] = 1'b1;
                m_busy[0] = 1'b0;
            end
        end
        #1;
        ncyc++;
    endtask

    task automatic idle();
        reset           = 1'b0;
        flush           = 1'b0;
        reg_write_back  = 1'b0;
        write_back_addr = 5'd0;
        write_back_data = 64'd0;
        issue_valid     = 1'b0;
        issue_reg_write = 1'b0;
        issue_rd        = 5'd0;
        rs1_addr        = 5'd0;
        rs2_addr        = 5'd0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        issue_valid     = 1'b1;
        issue_reg_write = 1'b1;
        issue_rd        = rd;
        rs1_addr        = s1;
        rs2_addr        = s2;
    endtask

    task automatic wb(input logic [4:0] a, input logic [63:0] d);
        reg_write_back  = 1'b1;
        write_back_addr = a;
        write_back_data = d;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        m_clear();

        // Reset cycle checked, then every address reads zero.
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            cycle();
        end

        // Bypass on x5, then array read.
        idle();
        wb(5'd5, 64'hDEAD_BEEF_0000_0001);
        rs1_addr = 5'd5;
        cycle();
        reg_write_back = 1'b0;
        cycle();

        // Writes to x0 are dropped.
        idle();
        wb(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        rs2_addr = 5'd0;
        cycle();
        reg_write_back = 1'b0;
        cycle();

        // RAW stall on x7 held three cycles, released by writeback of x7.
        idle();
        issue(5'd7, 5'd0, 5'd0);
        cycle();
        issue(5'd10, 5'd7, 5'd0);
        repeat (3) cycle();
        wb(5'd7, 64'h0123_4567_89AB_CDEF);
        cycle();
        idle();
        rs1_addr = 5'd7;
        cycle();

        // Issue to x9 in the same cycle x9 retires: busy stays set.
        idle();
        issue(5'd9, 5'd0, 5'd0);
        cycle();
        wb(5'd9, 64'h9999);
        issue(5'd9, 5'd0, 5'd0);
        cycle();
        idle();
        cycle();

        // Flush with concurrent writeback, then reset in the middle of a hazard.
        issue(5'd3, 5'd0, 5'd0);
        cycle();
        issue(5'd4, 5'd0, 5'd0);
        cycle();
        idle();
        flush = 1'b1;
        issue(5'd11, 5'd4, 5'd0);
        wb(5'd3, 64'h1234);
        cycle();
        idle();
        rs1_addr = 5'd3;
        rs2_addr = 5'd4;
        cycle();
        issue(5'd5, 5'd0, 5'd0);
        cycle();
        issue(5'd6, 5'd5, 5'd0);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();

        // Random traffic concentrated on a few registers to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            int hi;
            hi = (n % 4 == 0) ? 31 : 7;
            rs1_addr        = 5'($urandom_range(0, hi));
            rs2_addr        = 5'($urandom_range(0, hi));
            reg_write_back  = 1'($urandom_range(0, 1));
            write_back_addr = 5'($urandom_range(0, hi));
            write_back_data = {$urandom, $urandom};
            issue_valid     = ($urandom_range(0, 3) != 0);
            issue_reg_write = 1'($urandom_range(0, 1));
            issue_rd        = 5'($urandom_range(0, hi));
            flush           = ($urandom_range(0, 31) == 0);
            reset           = ($urandom_range(0, 199) == 0);
            cycle();
        end

        idle();
        cycle();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
